// File: rtl/pim_result_aggregator_pkg.sv
// Shared types for the PIM result aggregator: tile geometry and element width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package types;

  localparam int WIDTH             = 8;
  localparam int CHUNK_SIZE        = 2;
  localparam int PIM_UNIT_CAPACITY = 64;
  localparam int NUM_PIM_UNITS     = 2;

  localparam int TILE_ELEMS = CHUNK_SIZE * CHUNK_SIZE;
  // Wide enough to hold a count of 0..NUM_PIM_UNITS valid units in one cycle.
  localparam int PC_W       = $clog2(NUM_PIM_UNITS + 1);

  typedef logic [WIDTH-1:0] elem_t;
  // Row-major tile: element index = i*CHUNK_SIZE + j.
  typedef elem_t [TILE_ELEMS-1:0] tile_t;
  typedef tile_t [NUM_PIM_UNITS-1:0] unit_tiles_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCUM    = 2'd1,
    WAIT_OUT = 2'd2
  } agg_state_e;

endpackage

// File: rtl/pim_result_aggregator_adder.sv
// Sums the partial tiles of all valid PIM units element-wise and counts them.
// Latency: combinational.
// Backpressure: none; invalid units simply contribute zero.
module pim_partial_adder
  import types::*;
(
  input  unit_tiles_t              unit_result,
  input  logic [NUM_PIM_UNITS-1:0] unit_result_valid,
  output tile_t                    partial_sum,
  output logic [PC_W-1:0]          popcount
);

  // Element-wise wrap-around sum of every valid unit, plus the number of valid units.
  always_comb begin
    partial_sum = '0;
    popcount    = '0;
    for (int u = 0; u < NUM_PIM_UNITS; u++) begin
      if (unit_result_valid[u]) begin
        popcount = popcount + PC_W'(1);
        for (int e = 0; e < TILE_ELEMS; e++) begin
          partial_sum[e] = partial_sum[e] + unit_result[u][e];
        end
      end
    end
  end

endmodule

// File: rtl/pim_result_aggregator.sv
// Accumulates num_partials partial tiles from the PIM units into one output tile.
// Latency: tile presented on out_tile/out_valid one cycle after its last partial.
// Backpressure: a single output buffer; if still occupied, the finished sum parks in WAIT_OUT.
module pim_result_aggregator
  import types::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [CNT_W-1:0]         num_partials,
  input  unit_tiles_t              unit_result,
  input  logic [NUM_PIM_UNITS-1:0] unit_result_valid,
  output tile_t                    out_tile,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     unexpected_err
);

  agg_state_e       state_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] target_q;
  tile_t            acc_q;
  tile_t            out_tile_q;
  logic             out_valid_q;
  logic             done_q;
  logic             err_q;

  tile_t            partial_sum;
  logic [PC_W-1:0]  popcount;
  tile_t            acc_d;
  logic [CNT_W:0]   total_d;
  logic             complete;
  logic             overshoot;
  logic             out_free;

  pim_partial_adder u_adder (
    .unit_result       (unit_result),
    .unit_result_valid (unit_result_valid),
    .partial_sum       (partial_sum),
    .popcount          (popcount)
  );

  // Next accumulator value and partial count; one extra count bit so the compare never wraps.
  always_comb begin
    acc_d = '0;
    for (int e = 0; e < TILE_ELEMS; e++) begin
      acc_d[e] = acc_q[e] + partial_sum[e];
    end
    total_d   = {1'b0, count_q} + {{(CNT_W + 1 - PC_W){1'b0}}, popcount};
    complete  = (total_d >= {1'b0, target_q});
    overshoot = (total_d >  {1'b0, target_q});
    // Output buffer can take a new tile if empty or being drained this cycle.
    out_free  = !out_valid_q || out_ready;
  end

  // Control FSM together with counter, accumulator and output buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      target_q    <= '0;
      acc_q       <= '0;
      out_tile_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          // Partials arriving with no tile open are dropped.
          if (|unit_result_valid) begin
            err_q <= 1'b1;
          end
          if (start && (num_partials != '0)) begin
            acc_q    <= '0;
            count_q  <= '0;
            target_q <= num_partials;
            state_q  <= ACCUM;
          end
        end

        ACCUM: begin
          if (start) begin
            err_q <= 1'b1;
          end
          acc_q <= acc_d;
          if (complete) begin
            if (overshoot) begin
              err_q <= 1'b1;
            end
            count_q <= '0;
            if (out_free) begin
              out_tile_q  <= acc_d;
              out_valid_q <= 1'b1;
              done_q      <= 1'b1;
              state_q     <= IDLE;
            end else begin
              state_q <= WAIT_OUT;
            end
          end else begin
            count_q <= total_d[CNT_W-1:0];
          end
        end

        WAIT_OUT: begin
          if (start || (|unit_result_valid)) begin
            err_q <= 1'b1;
          end
          // Only entered with out_valid high, so out_ready here means the old tile drains now.
          if (out_ready) begin
            out_tile_q  <= acc_q;
            out_valid_q <= 1'b1;
            done_q      <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign out_tile       = out_tile_q;
  assign out_valid      = out_valid_q;
  assign done           = done_q;
  assign unexpected_err = err_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_pim_result_aggregator.sv
// Self-checking bench for pim_result_aggregator: vector table plus directed corner sequences.
// Latency: n/a.
// Backpressure: out_ready driven by the sequences; a scoreboard checks every handshaked tile.
module tb_pim_result_aggregator;
  import types::*;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start;
  logic [7:0]               num_partials;
  unit_tiles_t              unit_result;
  logic [NUM_PIM_UNITS-1:0] unit_result_valid;
  tile_t                    out_tile;
  logic                     out_valid;
  logic                     out_ready;
  logic                     busy;
  logic                     done;
  logic                     unexpected_err;

  int    checks   = 0;
  int    failures = 0;
  tile_t exp_q[$];
  tile_t mon_exp;

  typedef struct {
    logic [7:0] np;
    logic [1:0] mask;
    tile_t      u0;
    tile_t      u1;
    tile_t      exp_tile;
    logic       exp_err;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  pim_result_aggregator #(.CNT_W(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .num_partials      (num_partials),
    .unit_result       (unit_result),
    .unit_result_valid (unit_result_valid),
    .out_tile          (out_tile),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .busy              (busy),
    .done              (done),
    .unexpected_err    (unexpected_err)
  );

  function automatic tile_t mk(input int e0, input int e1, input int e2, input int e3);
    tile_t t;
    t[0] = e0[7:0];
    t[1] = e1[7:0];
    t[2] = e2[7:0];
    t[3] = e3[7:0];
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst               = 1'b1;
    start             = 1'b0;
    unit_result_valid = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Open a tile: one-cycle start pulse.
  task automatic open_tile(input logic [7:0] np);
    start        = 1'b1;
    num_partials = np;
    tick();
    start = 1'b0;
  endtask

  // Scoreboard: every accepted tile must match the oldest expected tile.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_tile: got %0h expected none", out_tile);
      end else begin
        mon_exp = exp_q.pop_front();
        check("tile_data", out_tile, mon_exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{8'd2, 2'b11, mk(1, 2, 3, 4), mk(10, 20, 30, 40), mk(11, 22, 33, 44), 1'b0};
    vecs[1] = '{8'd2, 2'b11, mk(200, 200, 200, 200), mk(100, 100, 100, 100), mk(44, 44, 44, 44), 1'b0};
    vecs[2] = '{8'd2, 2'b11, mk(255, 0, 128, 1), mk(1, 0, 128, 255), mk(0, 0, 0, 0), 1'b0};
    vecs[3] = '{8'd1, 2'b01, mk(5, 6, 7, 8), mk(99, 99, 99, 99), mk(5, 6, 7, 8), 1'b0};
    vecs[4] = '{8'd1, 2'b10, mk(99, 99, 99, 99), mk(9, 10, 11, 12), mk(9, 10, 11, 12), 1'b0};
    vecs[5] = '{8'd1, 2'b11, mk(1, 2, 3, 4), mk(10, 20, 30, 40), mk(11, 22, 33, 44), 1'b1};

    rst               = 1'b1;
    start             = 1'b0;
    num_partials      = '0;
    unit_result       = '0;
    unit_result_valid = '0;
    out_ready         = 1'b1;

    // Single-beat tiles from the table, each from a fresh reset.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", unexpected_err, 0);
      check("rst_out_tile", out_tile, 0);
      open_tile(vecs[i].np);
      check("accum_busy", busy, 1);
      unit_result[0]    = vecs[i].u0;
      unit_result[1]    = vecs[i].u1;
      unit_result_valid = vecs[i].mask;
      exp_q.push_back(vecs[i].exp_tile);
      tick();
      unit_result_valid = '0;
      check("vec_done", done, 1);
      check("vec_out_valid", out_valid, 1);
      check("vec_idle", busy, 0);
      check("vec_err", unexpected_err, vecs[i].exp_err);
      tick();
      check("vec_done_once", done, 0);
      check("vec_drained", out_valid, 0);
    end

    // Partials spread over cycles 1, 3, 5.
    do_reset();
    open_tile(8'd3);
    unit_result[0] = mk(1, 1, 1, 1);
    for (int k = 0; k < 3; k++) begin
      unit_result_valid = 2'b01;
      if (k == 2) exp_q.push_back(mk(3, 3, 3, 3));
      tick();
      unit_result_valid = '0;
      if (k < 2) begin
        check("spread_no_done", done, 0);
        tick();
        check("spread_busy", busy, 1);
      end
    end
    check("spread_done", done, 1);
    check("spread_err", unexpected_err, 0);
    tick();

    // Start with zero partials is ignored.
    do_reset();
    open_tile(8'd0);
    check("zero_np_idle", busy, 0);
    check("zero_np_err", unexpected_err, 0);

    // Backpressure: second tile parks in WAIT_OUT until the first drains.
    do_reset();
    out_ready = 1'b0;
    open_tile(8'd1);
    unit_result[0]    = mk(7, 7, 7, 7);
    unit_result_valid = 2'b01;
    exp_q.push_back(mk(7, 7, 7, 7));
    tick();
    unit_result_valid = '0;
    check("bp_first_done", done, 1);
    tick();
    check("bp_first_done_once", done, 0);
    open_tile(8'd1);
    unit_result[1]    = mk(9, 8, 7, 6);
    unit_result_valid = 2'b10;
    exp_q.push_back(mk(9, 8, 7, 6));
    tick();
    unit_result_valid = '0;
    check("bp_wait_busy", busy, 1);
    check("bp_wait_no_done", done, 0);
    check("bp_hold_tile", out_tile, mk(7, 7, 7, 7));
    tick();
    tick();
    check("bp_hold_tile_later", out_tile, mk(7, 7, 7, 7));
    check("bp_hold_valid", out_valid, 1);
    out_ready = 1'b1;
    tick();
    check("bp_second_done", done, 1);
    check("bp_second_tile", out_tile, mk(9, 8, 7, 6));
    check("bp_second_valid", out_valid, 1);
    check("bp_second_idle", busy, 0);
    tick();
    check("bp_drained", out_valid, 0);
    check("bp_done_once", done, 0);
    check("bp_err", unexpected_err, 0);

    // Stray partial in IDLE, then an overshooting tile: error is sticky, sum still lands.
    do_reset();
    unit_result[0]    = mk(50, 50, 50, 50);
    unit_result_valid = 2'b01;
    tick();
    unit_result_valid = '0;
    check("idle_valid_err", unexpected_err, 1);
    check("idle_valid_dropped", busy, 0);
    open_tile(8'd1);
    unit_result[0]    = mk(1, 2, 3, 4);
    unit_result[1]    = mk(10, 20, 30, 40);
    unit_result_valid = 2'b11;
    exp_q.push_back(mk(11, 22, 33, 44));
    tick();
    unit_result_valid = '0;
    check("overshoot_done", done, 1);
    check("sticky_err", unexpected_err, 1);
    tick();

    // Start during ACCUM is flagged and does not relatch num_partials.
    do_reset();
    open_tile(8'd2);
    open_tile(8'd5);
    check("start_in_accum_err", unexpected_err, 1);
    check("start_in_accum_busy", busy, 1);
    unit_result[0]    = mk(1, 1, 1, 1);
    unit_result[1]    = mk(2, 2, 2, 2);
    unit_result_valid = 2'b11;
    exp_q.push_back(mk(3, 3, 3, 3));
    tick();
    unit_result_valid = '0;
    check("start_in_accum_done", done, 1);
    tick();

    // Reset mid-ACCUM discards the tile; next tile starts clean.
    do_reset();
    open_tile(8'd3);
    unit_result[0]    = mk(1, 1, 1, 1);
    unit_result_valid = 2'b01;
    tick();
    unit_result_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("midrst_no_done", done, 0);
      check("midrst_no_valid", out_valid, 0);
      check("midrst_idle", busy, 0);
      tick();
    end
    open_tile(8'd1);
    unit_result[0]    = mk(5, 5, 5, 5);
    unit_result_valid = 2'b01;
    exp_q.push_back(mk(5, 5, 5, 5));
    tick();
    unit_result_valid = '0;
    check("midrst_done", done, 1);
    check("midrst_tile", out_tile, mk(5, 5, 5, 5));
    tick();
    tick();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
